sym2_tx: RTL and testbench

SYM2_TX -- requirements
Module: sym2_tx

---
 rtl/sym2_pkg.sv | 26 ++
 rtl/sym2_tick.sv | 35 +++
 rtl/sym2_tx.sv | 102 ++++++++++
 tb/tb_sym2_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sym2_pkg.sv
// Shared types and constants for the 2-bit symbol transmitter.
package sym2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StPar
    } state_e;

    localparam logic [1:0]  SymStart = 2'b11;
    localparam int unsigned FrameLen = 6;

    // Data symbol idx 0 is the MSB pair of the byte.
    function automatic logic [1:0] data_sym(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] s;
        unique case (idx)
            2'd0:    s = b[7:6];
            2'd1:    s = b[5:4];
            2'd2:    s = b[3:2];
            default: s = b[1:0];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sym2_tick.sv
// Symbol-period counter: pulses tick_o on the last cycle of each symbol period.
module sym2_tick #(
    parameter int unsigned SYM_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned    CntW   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SYM_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == CntMax);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sym2_tx.sv
// Serialises bytes into 6-symbol frames (START, D3..D0, PAR) on a 2-bit output.
module sym2_tx
    import sym2_pkg::*;
#(
    parameter int unsigned SYM_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       x1,
    output logic       x0,
    output logic       sym_valid,
    output logic       busy
);

    state_e     state_q;
    logic [7:0] data_q;
    logic [1:0] idx_q;
    logic [1:0] sym_q;
    logic       sym_valid_q;
    logic       busy_q;
    logic       din_ready_q;
    logic       accept;
    logic       tick;

    assign accept = (state_q == StIdle) && din_valid && din_ready_q;

    sym2_tick #(
        .SYM_DIV(SYM_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (state_q != StIdle),
        .tick_o(tick)
    );

    // Outputs are computed alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            idx_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            din_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    din_ready_q <= 1'b1;
                    if (accept) begin
                        data_q      <= din;
                        idx_q       <= '0;
                        sym_q       <= SymStart;
                        sym_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        din_ready_q <= 1'b0;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        sym_q   <= data_sym(data_q, 2'd0);
                        idx_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (idx_q == 2'd3) begin
                            sym_q   <= {1'b0, ^data_q};
                            state_q <= StPar;
                        end else begin
                            sym_q <= data_sym(data_q, idx_q + 2'd1);
                        end
                        idx_q <= idx_q + 2'd1;
                    end
                end
                StPar: begin
                    if (tick) begin
                        sym_q       <= '0;
                        sym_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        din_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign x1        = sym_q[1];
    assign x0        = sym_q[0];
    assign sym_valid = sym_valid_q;
    assign busy      = busy_q;
    assign din_ready = din_ready_q;

endmodule

// File: tb/tb_sym2_tx.sv
// Scoreboard bench for sym2_tx: SYM_DIV=1 and SYM_DIV=3 instances driven in parallel.
module tb_sym2_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, v1, rdy1, x1_1, x0_1, sv1, busy1;
    logic [7:0] din1;
    logic       rst3, v3, rdy3, x1_3, x0_3, sv3, busy3;
    logic [7:0] din3;

    sym2_tx #(.SYM_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst1), .din(din1), .din_valid(v1), .din_ready(rdy1),
        .x1(x1_1), .x0(x0_1), .sym_valid(sv1), .busy(busy1)
    );

    sym2_tx #(.SYM_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst3), .din(din3), .din_valid(v3), .din_ready(rdy3),
        .x1(x1_3), .x0(x0_3), .sym_valid(sv3), .busy(busy3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [1:0] q1[$];
    logic [1:0] q3[$];

    // Hand-computed frames.
    logic [1:0] fr_b4[6] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
    logic [1:0] fr_01[6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [1:0] fr_ff[6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every valid symbol must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (sv1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected symbol %b%b (cycle %0d)", x1_1, x0_1, cyc);
            end else begin
                check("dut1 symbol", 32'({x1_1, x0_1}), 32'(q1.pop_front()));
                check("dut1 busy with symbol", 32'(busy1), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (sv3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut3 unexpected symbol %b%b (cycle %0d)", x1_3, x0_3, cyc);
            end else begin
                check("dut3 symbol", 32'({x1_3, x0_3}), 32'(q3.pop_front()));
                check("dut3 busy with symbol", 32'(busy3), 32'd1);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            begin : p1
                int nb;
                int rb;
                int first_st;
                int second_st;
                logic prev;
                rst1 = 1'b1; din1 = '0; v1 = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("dut1 reset outputs", 32'({x1_1, x0_1, sv1, busy1, rdy1}), 32'd0);
                rst1 = 1'b0;
                @(negedge clk);
                check("dut1 din_ready after reset", 32'(rdy1), 32'd1);

                // Single frames, with din changed right after accept.
                for (int t = 0; t < 2; t++) begin
                    for (int i = 0; i < 6; i++) q1.push_back(t == 0 ? fr_b4[i] : fr_01[i]);
                    din1 = (t == 0) ? 8'hB4 : 8'h01;
                    v1   = 1'b1;
                    @(posedge clk);
                    #1 v1 = 1'b0; din1 = 8'h5A;
                    nb = 0; rb = 0;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        if (busy1) nb++;
                        if (busy1 && rdy1) rb++;
                    end
                    check("dut1 busy cycles", 32'(nb), 32'd6);
                    check("dut1 ready while busy", 32'(rb), 32'd0);
                end

                // Back-to-back with din_valid held high.
                for (int i = 0; i < 6; i++) q1.push_back(fr_b4[i]);
                for (int i = 0; i < 6; i++) q1.push_back(fr_01[i]);
                din1 = 8'hB4; v1 = 1'b1;
                @(posedge clk);
                #1 din1 = 8'h01;
                first_st = -1; second_st = -1; prev = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (sv1 && !prev) begin
                        if (first_st < 0) begin
                            first_st = cyc;
                        end else if (second_st < 0) begin
                            second_st = cyc;
                            v1 = 1'b0;
                            din1 = 8'h55;
                        end
                    end
                    prev = sv1;
                end
                check("dut1 back-to-back start spacing", 32'(second_st - first_st), 32'd7);

                // Reset during D1 aborts the frame.
                for (int i = 0; i < 4; i++) q1.push_back(fr_b4[i]);
                din1 = 8'hB4; v1 = 1'b1;
                @(posedge clk);
                #1 v1 = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst1 = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("dut1 outputs after abort", 32'({x1_1, x0_1, sv1, busy1, rdy1}), 32'd0);
                rst1 = 1'b0;
                @(negedge clk);
                check("dut1 din_ready after abort", 32'(rdy1), 32'd1);
                for (int i = 0; i < 6; i++) q1.push_back(fr_b4[i]);
                din1 = 8'hB4; v1 = 1'b1;
                @(posedge clk);
                #1 v1 = 1'b0;
                nb = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (busy1) nb++;
                end
                check("dut1 busy cycles after abort", 32'(nb), 32'd6);
            end
            begin : p3
                int nb;
                rst3 = 1'b1; din3 = '0; v3 = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("dut3 reset outputs", 32'({x1_3, x0_3, sv3, busy3, rdy3}), 32'd0);
                rst3 = 1'b0;
                @(negedge clk);
                check("dut3 din_ready after reset", 32'(rdy3), 32'd1);
                for (int i = 0; i < 6; i++) repeat (3) q3.push_back(fr_ff[i]);
                din3 = 8'hFF; v3 = 1'b1;
                @(posedge clk);
                #1 v3 = 1'b0; din3 = 8'h00;
                nb = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (busy3) nb++;
                end
                check("dut3 busy cycles", 32'(nb), 32'd18);
            end
        join
        @(negedge clk);
        check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
        check("dut3 scoreboard drained", 32'(q3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
